// File: rtl/mprj_pad_cfg_loader.sv
// Serial configuration loader for user-project GPIO pads: snapshots per-pad
// words, shifts them out over NUM_CHAINS lockstep chains, then pulses a load strobe.
module mprj_pad_cfg_loader #(
   parameter int NUM_PADS   = 38,
   parameter int CFG_BITS   = 13,
   parameter int NUM_CHAINS = 2,
   parameter int HALF       = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_PADS*CFG_BITS-1:0]   pad_cfg,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic                           serial_clock,
   output logic                           serial_load,
   output logic [NUM_CHAINS-1:0]          serial_data
);
   localparam int PPC   = NUM_PADS / NUM_CHAINS;
   localparam int TOTAL = PPC * CFG_BITS;
   localparam int W     = NUM_PADS * CFG_BITS;
   localparam int BW    = $clog2(TOTAL + 1);
   localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(TOTAL - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

   typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_LOAD, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [HW-1:0]           half_q, half_d;
   logic [W-1:0]            shadow_q, shadow_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic                    sclk_q, sclk_d, sload_q, sload_d;
   logic [NUM_CHAINS-1:0]   sdata_q, sdata_d;
   logic                    half_last;
   logic [BW-1:0]           idx;
   logic [W-1:0]            sh;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bit_q    <= '0;
         half_q   <= '0;
         shadow_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sclk_q   <= 1'b0;
         sload_q  <= 1'b0;
         sdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         half_q   <= half_d;
         shadow_q <= shadow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sclk_q   <= sclk_d;
         sload_q  <= sload_d;
         sdata_q  <= sdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      half_d    = half_q;
      shadow_d  = shadow_q;
      half_last = (half_q == HALF_LAST);
      case (state_q)
         S_IDLE: begin
            bit_d  = '0;
            half_d = '0;
            if (start) begin
               state_d  = S_LO;
               shadow_d = pad_cfg;
            end
         end
         S_LO: begin
            if (half_last) begin
               state_d = S_HI;
               half_d  = '0;
            end else begin
               half_d = half_q + 1'b1;
            end
         end
         S_HI: begin
            if (half_last) begin
               half_d  = '0;
               bit_d   = bit_q + 1'b1;
               state_d = (bit_q == BIT_LAST) ? S_LOAD : S_LO;
            end else begin
               half_d = half_q + 1'b1;
            end
         end
         S_LOAD: begin
            if (half_last) begin
               state_d = S_DONE;
               half_d  = '0;
            end else begin
               half_d = half_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from next state so they register alongside it;
   // in LOAD the count equals TOTAL, so the index is clamped to hold the last bit.
   always_comb begin
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      sclk_d  = (state_d == S_HI);
      sload_d = (state_d == S_LOAD);
      sdata_d = '0;
      sh      = '0;
      idx     = (bit_d > BIT_LAST) ? BIT_LAST : bit_d;
      if (state_d inside {S_LO, S_HI, S_LOAD}) begin
         for (int c = 0; c < NUM_CHAINS; c++) begin
            sh         = shadow_d >> (c*TOTAL + TOTAL - 1 - int'(idx));
            sdata_d[c] = sh[0];
         end
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign serial_clock = sclk_q;
   assign serial_load  = sload_q;
   assign serial_data  = sdata_q;

endmodule
